fetch_sequencer: RTL and testbench

- Instruction-side counterpart of the control-path decoder.
- Owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to the decoder with a valid/ready handshake.
- Consumes the decoder's resolution (branch, zero, pcOp, loaded return address) to pick the next PC.
- Non-speculative: one instruction in flight at a time.

---
 rtl/fetch_sequencer_pkg.sv | 41 ++++
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer_pc_next_calc.sv | 14 +
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch side: instruction classes, branch opcodes,
// the sequencer state type and the next-PC selection rule.
package fetch_sequencer_pkg;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_IMM = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;
    localparam logic [1:0] CLS_MEM = 2'd3;

    localparam logic [1:0] BR_U    = 2'd0;
    localparam logic [1:0] BR_NEG  = 2'd1;
    localparam logic [1:0] BR_POS  = 2'd2;
    localparam logic [1:0] BR_ZERO = 2'd3;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        ISSUE    = 2'd2,
        RESOLVE  = 2'd3
    } fetch_state_t;

    // Return path wins over a taken branch; all arithmetic wraps modulo 2^32.
    function automatic logic [31:0] next_pc(
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic        branch,
        input logic        zero,
        input logic        pc_op,
        input logic [31:0] ld_addr
    );
        logic signed [31:0] offset;
        offset = {{4{instr[25]}}, instr[25:0], 2'b00};
        if (pc_op)
            next_pc = {ld_addr[31:2], 2'b00};
        else if (instr[31:30] == CLS_BR && branch && zero)
            next_pc = pc + 32'd4 + offset;
        else
            next_pc = pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and decoder handshakes of the fetch sequencer.
// master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        res_valid;
    logic        branch;
    logic        zero;
    logic        pc_op;
    logic [31:0] ld_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
        input  imem_ack, imem_rdata, instr_ready, res_valid, branch, zero, pc_op, ld_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
        output imem_ack, imem_rdata, instr_ready, res_valid, branch, zero, pc_op, ld_addr
    );
endinterface

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC selection: return address, taken branch or fall-through.
module pc_next_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        pc_op,
    input  logic [31:0] ld_addr,
    output logic [31:0] pc_nxt
);
    assign pc_nxt = next_pc(pc, instr, branch, zero, pc_op, ld_addr);
endmodule

// File: rtl/fetch_sequencer.sv
// Non-speculative fetch sequencer: owns the PC, fetches one instruction at a
// time, hands it to the decoder and steers the PC from the decoder's resolution.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus,
    output logic               fetch_err,
    output logic [CNT_W-1:0]   retired
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         imem_req;
    logic [15:0]  to_cnt;
    logic         take_ack;
    logic         timeout_hit;
    logic         accept;
    logic         resolve;

    pc_next_calc u_pc_next (
        .pc      (pc),
        .instr   (instr),
        .branch  (bus.branch),
        .zero    (bus.zero),
        .pc_op   (bus.pc_op),
        .ld_addr (bus.ld_addr),
        .pc_nxt  (pc_nxt)
    );

    // An ack in the final wait cycle is checked first, so it beats the timeout.
    always_comb begin
        state_nxt   = state;
        take_ack    = 1'b0;
        timeout_hit = 1'b0;
        accept      = 1'b0;
        resolve     = 1'b0;
        case (state)
            FETCH: state_nxt = WAIT_MEM;
            WAIT_MEM: begin
                if (bus.imem_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = ISSUE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    accept    = 1'b1;
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                if (bus.res_valid) begin
                    resolve   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            retired     <= '0;
            to_cnt      <= 16'd0;
        end else begin
            state     <= state_nxt;
            imem_req  <= (state_nxt == WAIT_MEM);
            fetch_err <= timeout_hit;
            if (state == FETCH)
                to_cnt <= 16'd0;
            else if (state == WAIT_MEM && !bus.imem_ack)
                to_cnt <= to_cnt + 16'd1;
            if (take_ack) begin
                instr       <= bus.imem_rdata;
                instr_valid <= 1'b1;
            end else if (accept) begin
                instr_valid <= 1'b0;
            end
            if (resolve) begin
                pc      <= pc_nxt;
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a transaction-level PC/retire model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_err;
    logic [31:0] retired;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fetch_err (fetch_err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          err_pulses = 0;
    logic        chk_en = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] exp_ret = 32'd0;
    logic [31:0] exp_instr = 32'd0;

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endfunction

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               input logic br, input logic z, input logic op,
                                               input logic [31:0] ld);
        longint off;
        if (op)
            return ld & 32'hFFFF_FFFC;
        if (w[31:30] == 2'b10 && br && z) begin
            off = longint'(w[25:0]);
            if (w[25])
                off = off - 64'd67108864;
            return 32'(longint'(pc) + 4 + off * 4);
        end
        return pc + 32'd4;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check32("pc", bus.pc, exp_pc);
            check32("pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
            check32("retired", retired, exp_ret);
            if (bus.imem_req)
                check32("imem_addr", bus.imem_addr, exp_pc);
            if (bus.instr_valid)
                check32("instr", bus.instr, exp_instr);
        end
        if (fetch_err)
            err_pulses++;
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check32("req_seen", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] want_addr, input logic [31:0] word,
                             input logic br, input logic z, input logic op, input logic [31:0] ld,
                             input int ack_dly, input int rdy_dly, input int res_dly);
        wait_req();
        check32("fetch_addr", bus.imem_addr, want_addr);
        for (int i = 0; i < ack_dly; i++) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        exp_instr      = word;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        check32("valid_set", 32'(bus.instr_valid), 32'd1);
        check32("req_drop", 32'(bus.imem_req), 32'd0);
        // Stray ack/res_valid while stalled must not disturb the presented instruction.
        for (int i = 0; i < rdy_dly; i++) begin
            bus.imem_ack   = (i == 1);
            bus.imem_rdata = 32'hBAD0_BAD0;
            bus.res_valid  = (i == 2);
            @(negedge clk);
            check32("valid_hold", 32'(bus.instr_valid), 32'd1);
            check32("instr_hold", bus.instr, word);
        end
        bus.imem_ack    = 1'b0;
        bus.res_valid   = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check32("valid_clr", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < res_dly; i++) @(negedge clk);
        bus.res_valid = 1'b1;
        bus.branch    = br;
        bus.zero      = z;
        bus.pc_op     = op;
        bus.ld_addr   = ld;
        @(posedge clk);
        exp_pc  = model_next(exp_pc, word, br, z, op, ld);
        exp_ret = exp_ret + 32'd1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.branch    = 1'b0;
        bus.zero      = 1'b0;
        bus.pc_op     = 1'b0;
        bus.ld_addr   = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        bus.pc_op       = 1'b0;
        bus.ld_addr     = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_req", 32'(bus.imem_req), 32'd0);
        check32("rst_valid", 32'(bus.instr_valid), 32'd0);
        check32("rst_instr", bus.instr, 32'd0);
        check32("rst_err", 32'(fetch_err), 32'd0);
        check32("rst_retired", retired, 32'd0);
        check32("rst_pc", bus.pc, 32'd0);
        rst     = 1'b0;
        exp_pc  = 32'd0;
        exp_ret = 32'd0;
        chk_en  = 1'b1;

        // Sequential fetch
        run_instr(32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
        run_instr(32'h4, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        run_instr(32'h8, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        run_instr(32'hC, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1, 0, 0);
        check32("retired_4", retired, 32'd4);

        // Taken branch, return with priority over branch, not-taken branch
        run_instr(32'h10,  32'h8000_0003, 1'b1, 1'b1, 1'b0, 32'h0,   0, 0, 0);
        run_instr(32'h20,  32'h8000_0003, 1'b1, 1'b1, 1'b1, 32'h13,  0, 0, 0);
        run_instr(32'h10,  32'h8000_0003, 1'b1, 1'b0, 1'b0, 32'h0,   0, 0, 0);
        run_instr(32'h14,  32'h8000_0003, 1'b1, 1'b1, 1'b1, 32'h123, 0, 0, 0);
        run_instr(32'h120, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0,   0, 0, 0);

        // Backward branch wrapping below zero, then wrap back up; IMM class never branches
        run_instr(32'h0, 32'h83FF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, 0);
        check32("wrap_pc", bus.pc, 32'hFFFF_FFFC);
        check32("wrap_pc4", bus.pc_plus4, 32'h0);
        run_instr(32'hFFFF_FFFC, 32'h4000_0005, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, 0);
        check32("wrap_back", bus.pc, 32'h0);

        // Timeout: 16 request cycles, one-cycle error with req low, late ack discarded
        e0 = err_pulses;
        wait_req();
        n = 0;
        while (bus.imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check32("timeout_cycles", 32'(n), 32'd16);
        check32("timeout_err", 32'(fetch_err), 32'd1);
        check32("timeout_req_low", 32'(bus.imem_req), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check32("rereq", 32'(bus.imem_req), 32'd1);
        check32("rereq_addr", bus.imem_addr, 32'h0);
        check32("err_cleared", 32'(fetch_err), 32'd0);
        check32("err_once", 32'(err_pulses - e0), 32'd1);

        // Ack in the 16th wait cycle is accepted without error
        e0 = err_pulses;
        run_instr(32'h0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0, 15, 0, 0);
        check32("late_ack_no_err", 32'(err_pulses - e0), 32'd0);

        // Backpressure and delayed resolution
        run_instr(32'h4, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 2, 5, 3);
        check32("retired_after_bp", retired, 32'd13);

        // Reset in the middle of a memory wait
        wait_req();
        @(negedge clk);
        chk_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check32("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check32("mid_rst_pc", bus.pc, 32'd0);
        check32("mid_rst_retired", retired, 32'd0);
        check32("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        rst     = 1'b0;
        exp_pc  = 32'd0;
        exp_ret = 32'd0;
        chk_en  = 1'b1;
        run_instr(32'h0, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
        check32("post_rst_pc", bus.pc, 32'h4);
        check32("post_rst_retired", retired, 32'd1);

        chk_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
